// File: rtl/lap_stopwatch_core.sv
// Stopwatch / countdown core: DIGITS-wide BCD count with tick prescaler,
// up/down direction, preset load, lap freeze and blinking expiry indication.
module lap_stopwatch_core #(
  parameter int TICK_DIV    = 5000000,
  parameter int DIGITS      = 4,
  parameter int FLASH_TICKS = 5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_up,
  input  logic                i_load,
  input  logic [4*DIGITS-1:0] i_preset,
  input  logic                i_lap,
  output logic [4*DIGITS-1:0] o_count_bcd,
  output logic [4*DIGITS-1:0] o_display_bcd,
  output logic                o_running,
  output logic                o_expired,
  output logic                o_blank,
  output logic                o_lap_active,
  output logic                o_wrap
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_TICKS - 1);
  localparam logic [FW-1:0] FLASH_ONE  = FW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Returns {carry_out, value + 1} in BCD.
  function automatic logic [CW:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c && (v[4*i +: 4] >= 4'd9)) begin
        r[4*i +: 4] = 4'd0;
      end else if (c) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
        c           = 1'b0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return {c, r};
  endfunction

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b && (v[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = 4'd9;
      end else if (b) begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
        b           = 1'b0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Non-decimal preset digits are clamped to 9.
  function automatic logic [CW-1:0] bcd_sat(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_snap;
  logic          r_lap;
  logic          r_dir;
  logic [PW-1:0] r_presc;
  logic [FW-1:0] r_flash;
  logic          r_blank;

  state_t        w_state_nx;
  logic [CW-1:0] w_count_nx;
  logic [CW-1:0] w_snap_nx;
  logic          w_lap_nx;
  logic          w_dir_nx;
  logic [PW-1:0] w_presc_nx;
  logic [FW-1:0] w_flash_nx;
  logic          w_blank_nx;
  logic          w_wrap_nx;

  logic [CW:0]   w_inc;
  logic [CW-1:0] w_dec;
  logic [CW-1:0] w_preset_sat;
  logic          w_tick;
  logic          w_expire;
  logic          w_start_ok;

  assign w_inc        = bcd_inc(r_count);
  assign w_dec        = bcd_dec(r_count);
  assign w_preset_sat = bcd_sat(i_preset);
  assign w_tick       = (r_presc == PRESC_LAST);
  assign w_expire     = w_tick && !r_dir && (w_dec == '0);
  // Outside RUN the direction register is transparent, so i_up is the effective direction.
  assign w_start_ok   = i_start && !i_stop && (i_up || (r_count != '0));

  // Next-state logic for the controller, count, lap and flash machinery.
  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_snap_nx  = r_snap;
    w_lap_nx   = r_lap;
    w_presc_nx = r_presc;
    w_flash_nx = r_flash;
    w_blank_nx = r_blank;
    w_wrap_nx  = 1'b0;
    w_dir_nx   = i_up;
    case (r_state)
      ST_RUN: begin
        w_dir_nx = r_dir;
        if (w_tick) begin
          w_presc_nx = '0;
        end else begin
          w_presc_nx = r_presc + PRESC_ONE;
        end
        if (i_lap && r_lap) begin
          w_lap_nx = 1'b0;
        end else if (i_lap) begin
          w_snap_nx = r_count;
          w_lap_nx  = 1'b1;
        end else begin
          w_lap_nx = r_lap;
        end
        if (w_tick && r_dir) begin
          w_count_nx = w_inc[CW-1:0];
          w_wrap_nx  = w_inc[CW];
        end else if (w_tick) begin
          w_count_nx = w_dec;
        end else begin
          w_count_nx = r_count;
        end
        if (w_expire) begin
          w_state_nx = ST_EXPIRED;
          w_lap_nx   = 1'b0;
          w_blank_nx = 1'b1;
          w_flash_nx = '0;
        end else if (i_stop) begin
          w_state_nx = ST_PAUSED;
        end else begin
          w_state_nx = ST_RUN;
        end
      end
      ST_IDLE, ST_PAUSED, ST_EXPIRED: begin
        if ((r_state == ST_EXPIRED) && w_tick) begin
          w_presc_nx = '0;
          if (r_flash == FLASH_LAST) begin
            w_flash_nx = '0;
            w_blank_nx = ~r_blank;
          end else begin
            w_flash_nx = r_flash + FLASH_ONE;
          end
        end else if (r_state == ST_EXPIRED) begin
          w_presc_nx = r_presc + PRESC_ONE;
        end else begin
          w_presc_nx = r_presc;
        end
        if (i_lap) begin
          w_lap_nx = 1'b0;
        end else begin
          w_lap_nx = r_lap;
        end
        if (i_load) begin
          w_count_nx = w_preset_sat;
          w_lap_nx   = 1'b0;
          w_blank_nx = 1'b0;
          w_state_nx = ST_IDLE;
        end else if (w_start_ok) begin
          w_presc_nx = '0;
          w_flash_nx = '0;
          w_blank_nx = 1'b0;
          w_state_nx = ST_RUN;
        end else begin
          w_state_nx = r_state;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State and output registers; outputs are derived from next-state values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_snap        <= '0;
      r_lap         <= 1'b0;
      r_dir         <= 1'b1;
      r_presc       <= '0;
      r_flash       <= '0;
      r_blank       <= 1'b0;
      o_display_bcd <= '0;
      o_running     <= 1'b0;
      o_expired     <= 1'b0;
      o_wrap        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_count       <= w_count_nx;
      r_snap        <= w_snap_nx;
      r_lap         <= w_lap_nx;
      r_dir         <= w_dir_nx;
      r_presc       <= w_presc_nx;
      r_flash       <= w_flash_nx;
      r_blank       <= w_blank_nx;
      o_display_bcd <= w_lap_nx ? w_snap_nx : w_count_nx;
      o_running     <= (w_state_nx == ST_RUN);
      o_expired     <= (w_state_nx == ST_EXPIRED);
      o_wrap        <= w_wrap_nx;
    end
  end

  assign o_count_bcd  = r_count;
  assign o_blank      = r_blank;
  assign o_lap_active = r_lap;

endmodule

// File: tb/tb_lap_stopwatch_core.sv
// Directed and randomized bench for lap_stopwatch_core against a decimal
// behavioural model of the stopwatch rules.
module tb_lap_stopwatch_core;

  localparam int TD   = 4;
  localparam int ND   = 4;
  localparam int FT   = 2;
  localparam int CW   = 4 * ND;
  localparam int MAXV = 10000;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

  logic          clk = 1'b0;
  logic          reset, start, stop, up, load, lap;
  logic [CW-1:0] preset;
  logic [CW-1:0] count_bcd, display_bcd;
  logic          running, expired, blank, lap_active, wrap;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  int m_state, m_cnt, m_snap, m_phase, m_fticks;
  bit m_lap, m_dir, m_blank, m_wrap;

  always #5 clk = ~clk;

  lap_stopwatch_core #(.TICK_DIV(TD), .DIGITS(ND), .FLASH_TICKS(FT)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop), .i_up(up),
    .i_load(load), .i_preset(preset), .i_lap(lap),
    .o_count_bcd(count_bcd), .o_display_bcd(display_bcd), .o_running(running),
    .o_expired(expired), .o_blank(blank), .o_lap_active(lap_active), .o_wrap(wrap)
  );

  function automatic logic [CW-1:0] to_bcd(input int v);
    logic [CW-1:0] r;
    int            x;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int sat_val(input logic [CW-1:0] p);
    int v, d;
    v = 0;
    for (int i = ND - 1; i >= 0; i--) begin
      d = int'(p[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit tick;
    if (reset) begin
      m_state = S_IDLE; m_cnt = 0; m_snap = 0; m_lap = 0; m_dir = 1;
      m_phase = 0; m_fticks = 0; m_blank = 0; m_wrap = 0;
    end else if (m_state == S_RUN) begin
      tick = (m_phase == TD - 1);
      m_phase = tick ? 0 : m_phase + 1;
      m_wrap = 0;
      if (lap) begin
        if (m_lap) m_lap = 0;
        else begin m_snap = m_cnt; m_lap = 1; end
      end
      if (tick && m_dir) begin
        if (m_cnt == MAXV - 1) begin m_cnt = 0; m_wrap = 1; end
        else m_cnt++;
      end else if (tick) begin
        m_cnt--;
        if (m_cnt == 0) begin m_state = S_EXP; m_lap = 0; m_blank = 1; m_fticks = 0; end
      end
      if (stop && m_state == S_RUN) m_state = S_PAUSE;
    end else begin
      m_wrap = 0;
      if (m_state == S_EXP) begin
        tick = (m_phase == TD - 1);
        m_phase = tick ? 0 : m_phase + 1;
        if (tick) begin
          m_fticks++;
          if (m_fticks == FT) begin m_fticks = 0; m_blank = !m_blank; end
        end
      end
      if (lap) m_lap = 0;
      if (load) begin
        m_cnt = sat_val(preset); m_lap = 0; m_state = S_IDLE; m_blank = 0;
      end else if (start && !stop && (up || m_cnt != 0)) begin
        m_state = S_RUN; m_phase = 0; m_blank = 0;
      end
      m_dir = up;
    end
  endtask

  task automatic check_all();
    check("count_bcd", 32'(count_bcd), 32'(to_bcd(m_cnt)));
    check("display_bcd", 32'(display_bcd), 32'(m_lap ? to_bcd(m_snap) : to_bcd(m_cnt)));
    check("running", 32'(running), 32'(m_state == S_RUN));
    check("expired", 32'(expired), 32'(m_state == S_EXP));
    check("blank", 32'(blank), 32'(m_blank));
    check("lap_active", 32'(lap_active), 32'(m_lap));
    check("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      model_update();
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic do_load(input logic [CW-1:0] v);
    preset = v; load = 1'b1; step(); load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; up = 1'b1; load = 1'b0; lap = 1'b0;
    preset = '0;
    step(2);
    check("reset_count", 32'(count_bcd), 32'h0);
    reset = 1'b0;
    step(2);

    // Up count: first tick TICK_DIV cycles after start.
    pulse_start();
    step(4);
    check("up_first_tick", 32'(count_bcd), 32'h0001);
    step(4);
    check("up_second_tick", 32'(count_bcd), 32'h0002);
    pulse_stop();
    step(6);
    check("stop_holds", 32'(count_bcd), 32'h0002);

    // Rollover across all digits.
    do_load(16'h9998);
    pulse_start();
    step(8);
    check("rollover_zero", 32'(count_bcd), 32'h0000);
    check("rollover_wrap", 32'(wrap), 32'h1);
    step();
    check("wrap_one_cycle", 32'(wrap), 32'h0);
    step(3);
    check("after_rollover", 32'(count_bcd), 32'h0001);
    pulse_stop();

    // Countdown to expiry and flashing.
    up = 1'b0;
    step();
    do_load(16'h0003);
    pulse_start();
    step(12);
    check("expire_count", 32'(count_bcd), 32'h0000);
    check("expire_flag", 32'(expired), 32'h1);
    check("expire_blank", 32'(blank), 32'h1);
    step(8);
    check("flash_toggle", 32'(blank), 32'h0);
    pulse_start();
    check("start_ignored", 32'(expired), 32'h1);
    do_load(16'h0005);
    check("load_exits", 32'(expired), 32'h0);
    check("load_unblank", 32'(blank), 32'h0);

    // Lap freeze and release.
    up = 1'b1;
    step();
    do_load(16'h0006);
    pulse_start();
    step(4);
    lap = 1'b1; step(); lap = 1'b0;
    step(11);
    check("lap_count_live", 32'(count_bcd), 32'h0010);
    check("lap_frozen", 32'(display_bcd), 32'h0007);
    lap = 1'b1; step(); lap = 1'b0;
    check("lap_released", 32'(display_bcd), 32'h0010);
    pulse_stop();

    // Borrow across digits.
    up = 1'b0;
    step();
    do_load(16'h1000);
    pulse_start();
    step(4);
    check("borrow", 32'(count_bcd), 32'h0999);

    // Conflicts: stop beats start, direction frozen while running.
    pulse_stop();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check("start_stop_conflict", 32'(running), 32'h0);
    pulse_start();
    up = 1'b1;
    step(8);
    check("dir_frozen", 32'(count_bcd), 32'h0997);
    pulse_stop();

    // Reset in the middle of flashing.
    up = 1'b0;
    step();
    do_load(16'h0001);
    pulse_start();
    step(9);
    reset = 1'b1; step(); reset = 1'b0;
    check("reset_flash_exp", 32'(expired), 32'h0);
    check("reset_flash_cnt", 32'(count_bcd), 32'h0);

    // Randomized traffic.
    for (int it = 0; it < 2000; it++) begin
      start  = ($urandom_range(7) == 0);
      stop   = ($urandom_range(15) == 0);
      load   = ($urandom_range(31) == 0);
      lap    = ($urandom_range(15) == 0);
      reset  = ($urandom_range(399) == 0);
      preset = 16'($urandom);
      if ($urandom_range(15) == 0) up = ~up;
      step();
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; lap = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
